cc_cond_unit: RTL and testbench

//   Condition-code register and condition evaluator for the SEQ datapath; the consumer end
//   of the ALU_wrapper output interface (out, OF).

---
 rtl/cc_cond_unit.sv | 86 ++++++++
 tb/tb_cc_cond_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cc_cond_unit.sv
// Condition-code register and jXX/cmovXX condition evaluator.
// Captures ZF/SF/OF from the ALU on OPq and drives cnd.
module cc_cond_unit #(
  parameter int WIDTH  = 64,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_of,
  input  logic             set_cc,
  input  logic             stall,
  input  logic [3:0]       ifun,
  input  logic             cond_en,
  output logic [2:0]       cc_out,
  output logic             cnd,
  output logic             cond_err
);

  localparam logic [0:0] S_RESET_CC = 1'b0;
  localparam logic [0:0] S_LIVE     = 1'b1;

  logic [2:0] cc_q, cc_d;
  logic [2:0] nxt_flags;
  logic [2:0] sel_flags;
  logic [0:0] state_q, state_d;
  logic       err_q, err_d;
  logic       upd;
  logic       illegal;
  logic       zf, sf, of;

  assign nxt_flags = {~|alu_out, alu_out[WIDTH-1], alu_of};
  assign upd       = set_cc & ~stall;
  assign illegal   = cond_en & (ifun > 4'd6);

  // Next-state: flags load on an accepted update, first one goes LIVE
  always_comb begin
    cc_d    = cc_q;
    state_d = state_q;
    if (upd) begin
      cc_d    = nxt_flags;
      state_d = S_LIVE;
    end
  end

  assign err_d = err_q | illegal;

  // Flag, state and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q    <= 3'b100;
      state_q <= S_RESET_CC;
      err_q   <= 1'b0;
    end else begin
      cc_q    <= cc_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign sel_flags = ((BYPASS != 0) && upd) ? nxt_flags : cc_q;
  assign zf = sel_flags[2];
  assign sf = sel_flags[1];
  assign of = sel_flags[0];

  // Condition decode against the selected flags
  always_comb begin
    cnd = 1'b0;
    if (cond_en) begin
      case (ifun)
        4'd0:    cnd = 1'b1;
        4'd1:    cnd = (sf ^ of) | zf;
        4'd2:    cnd = sf ^ of;
        4'd3:    cnd = zf;
        4'd4:    cnd = ~zf;
        4'd5:    cnd = ~(sf ^ of);
        4'd6:    cnd = ~(sf ^ of) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign cc_out   = cc_q;
  assign cond_err = err_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Testbench for cc_cond_unit: table of vectors plus
// hand sequences for reset, bypass and sticky error.
module tb_cc_cond_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_out;
  logic        alu_of, set_cc, stall, cond_en;
  logic [3:0]  ifun;
  logic [2:0]  cc0, cc1;
  logic        cnd0, cnd1, err0, err1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cc_cond_unit #(.WIDTH(64), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_of(alu_of),
    .set_cc(set_cc), .stall(stall), .ifun(ifun), .cond_en(cond_en),
    .cc_out(cc0), .cnd(cnd0), .cond_err(err0)
  );

  cc_cond_unit #(.WIDTH(64), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_of(alu_of),
    .set_cc(set_cc), .stall(stall), .ifun(ifun), .cond_en(cond_en),
    .cc_out(cc1), .cnd(cnd1), .cond_err(err1)
  );

  typedef struct {
    logic        set_cc;
    logic        stall;
    logic [63:0] alu_out;
    logic        alu_of;
    logic [3:0]  ifun;
    logic        cond_en;
    logic        cnd0;
    logic        cnd1;
    logic [2:0]  cc;
    logic        err;
  } vec_t;

  vec_t v[13];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sc, input logic st,
                       input logic [63:0] ao, input logic of,
                       input logic [3:0] fn, input logic en);
    set_cc  = sc;
    stall   = st;
    alu_out = ao;
    alu_of  = of;
    ifun    = fn;
    cond_en = en;
  endtask

  initial begin
    v[0]  = '{1, 0, 64'h0, 0, 4'd3, 1, 1, 1, 3'b100, 0};
    v[1]  = '{1, 0, 64'h8000_0000_0000_0000, 1, 4'd2, 1, 0, 0, 3'b011, 0};
    v[2]  = '{0, 0, 64'h0, 0, 4'd2, 1, 0, 0, 3'b011, 0};
    v[3]  = '{0, 0, 64'h0, 0, 4'd5, 1, 1, 1, 3'b011, 0};
    v[4]  = '{1, 1, 64'h5, 0, 4'd0, 1, 1, 1, 3'b011, 0};
    v[5]  = '{1, 0, 64'h5, 0, 4'd1, 1, 0, 0, 3'b000, 0};
    v[6]  = '{0, 0, 64'h0, 0, 4'd6, 1, 1, 1, 3'b000, 0};
    v[7]  = '{0, 0, 64'h0, 0, 4'd1, 1, 0, 0, 3'b000, 0};
    v[8]  = '{0, 0, 64'h0, 0, 4'd4, 1, 1, 1, 3'b000, 0};
    v[9]  = '{0, 0, 64'h0, 0, 4'd3, 0, 0, 0, 3'b000, 0};
    v[10] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd2, 1, 0, 1, 3'b010, 0};
    v[11] = '{0, 0, 64'h0, 0, 4'd5, 1, 0, 0, 3'b010, 0};
    v[12] = '{0, 0, 64'h0, 0, 4'hA, 0, 0, 0, 3'b010, 0};

    rst = 1'b1;
    drive(0, 0, 64'h0, 0, 4'd3, 1);
    #12;
    chk("reset_cc", {5'b0, cc0}, 8'h4);
    chk("reset_err", {7'b0, err0}, 8'h0);
    chk("reset_cnd_e", {7'b0, cnd0}, 8'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(v[i].set_cc, v[i].stall, v[i].alu_out, v[i].alu_of,
            v[i].ifun, v[i].cond_en);
      #1;
      chk($sformatf("v%0d_cnd_b0", i), {7'b0, cnd0}, {7'b0, v[i].cnd0});
      chk($sformatf("v%0d_cnd_b1", i), {7'b0, cnd1}, {7'b0, v[i].cnd1});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cc0", i), {5'b0, cc0}, {5'b0, v[i].cc});
      chk($sformatf("v%0d_cc1", i), {5'b0, cc1}, {5'b0, v[i].cc});
      chk($sformatf("v%0d_err", i), {7'b0, err0}, {7'b0, v[i].err});
    end

    // async reset between edges, no clock edge needed
    @(negedge clk);
    drive(0, 0, 64'h0, 0, 4'd3, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cc", {5'b0, cc0}, 8'h4);
    chk("async_rst_cnd", {7'b0, cnd0}, 8'h1);
    #1 rst = 1'b0;

    // same-cycle update with condition: bypass difference
    @(negedge clk);
    drive(1, 0, 64'h7, 0, 4'd3, 1);
    #1;
    chk("byp0_cnd", {7'b0, cnd0}, 8'h1);
    chk("byp1_cnd", {7'b0, cnd1}, 8'h0);
    @(posedge clk);
    #1;
    chk("byp_cc_after", {5'b0, cc0}, 8'h0);

    // reset held across an edge overrides pending update
    @(negedge clk);
    drive(1, 0, 64'h8000_0000_0000_0000, 1, 4'd0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_upd", {5'b0, cc0}, 8'h4);
    @(negedge clk);
    rst = 1'b0;

    // illegal ifun with stall: cnd 0, error sticks
    drive(0, 1, 64'h0, 0, 4'hA, 1);
    #1;
    chk("illegal_cnd", {7'b0, cnd0}, 8'h0);
    chk("illegal_err_pre", {7'b0, err0}, 8'h0);
    @(posedge clk);
    #1;
    chk("illegal_err", {7'b0, err0}, 8'h1);
    chk("illegal_err_b1", {7'b0, err1}, 8'h1);
    @(negedge clk);
    drive(0, 0, 64'h0, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("err_hold%0d", k), {7'b0, err0}, 8'h1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("err_cleared", {7'b0, err0}, 8'h0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
